fib_access_arb: RTL

//  Round-robin arbiter that shares the single-port FIB table memory (behave1p_mem)

---
 rtl/fib_access_arb.sv | 114 +++++++++++
 1 files changed

// File: rtl/fib_access_arb.sv
// fib_access_arb: round-robin arbiter for the single-port FIB table.
// One access per cycle; read results are routed back to their owner.
module fib_access_arb #(
    parameter int NUM_REQ = 3,
    parameter int ASZ     = 8,
    parameter int DSZ     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     rq_srdy,
    output logic [NUM_REQ-1:0]     rq_drdy,
    input  logic [NUM_REQ-1:0]     rq_wr,
    input  logic [NUM_REQ*ASZ-1:0] rq_addr,
    input  logic [NUM_REQ*DSZ-1:0] rq_wdata,
    output logic [NUM_REQ-1:0]     rs_srdy,
    input  logic [NUM_REQ-1:0]     rs_drdy,
    output logic [NUM_REQ*DSZ-1:0] rs_data,
    output logic [ASZ-1:0]         ft_addr,
    output logic [DSZ-1:0]         ft_wdata,
    output logic                   ft_rd_n,
    output logic                   ft_wr_n,
    input  logic [DSZ-1:0]         ft_rdata
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      rd_id;
    logic [IW-1:0]      gnt_id;
    logic               rd_pend;
    logic               gnt_vld;
    logic               gnt_wr;
    logic [NUM_REQ-1:0] elig;

    // A read waits for its own in-flight read and a free response slot
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = rq_srdy[i] &&
                      (rq_wr[i] ||
                       (!(rd_pend && (rd_id == IW'(i))) &&
                        (!rs_srdy[i] || rs_drdy[i])));
        end
    end

    // Pick the first eligible requester at or after rr_ptr
    always_comb begin : scan_p
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_vld && reset && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = IW'(idx);
            end
        end
    end

    // Drive the accept strobe and the memory port from the winner
    always_comb begin
        rq_drdy  = '0;
        gnt_wr   = 1'b0;
        ft_addr  = '0;
        ft_wdata = '0;
        ft_rd_n  = 1'b1;
        ft_wr_n  = 1'b1;
        if (gnt_vld) begin
            rq_drdy[gnt_id] = 1'b1;
            gnt_wr   = rq_wr[gnt_id];
            ft_addr  = rq_addr[int'(gnt_id)*ASZ +: ASZ];
            ft_wdata = rq_wdata[int'(gnt_id)*DSZ +: DSZ];
            ft_rd_n  = gnt_wr;
            ft_wr_n  = !gnt_wr;
        end
    end

    // Advance the round-robin pointer and track the read in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr  <= '0;
            rd_pend <= 1'b0;
            rd_id   <= '0;
        end else begin
            rd_pend <= gnt_vld && !gnt_wr;
            if (gnt_vld) begin
                rr_ptr <= (gnt_id == IW'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
            end
            if (gnt_vld && !gnt_wr) begin
                rd_id <= gnt_id;
            end
        end
    end

    // Response slots: a returning read wins over a same-cycle drain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_srdy <= '0;
            rs_data <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rd_pend && (rd_id == IW'(i))) begin
                    rs_srdy[i]              <= 1'b1;
                    rs_data[i*DSZ +: DSZ]   <= ft_rdata;
                end else if (rs_drdy[i]) begin
                    rs_srdy[i] <= 1'b0;
                end
            end
        end
    end

endmodule
